stream_queue: RTL and testbench

STREAM_QUEUE -- requirements
Module: stream_queue

---
 rtl/stream_queue.sv | 119 +++++++++++
 tb/tb_stream_queue.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_queue.sv
// stream_queue: bit-granular circular FIFO with variable-width
// enqueue/dequeue, occupancy counters and threshold flags.
module stream_queue #(
   parameter int IN_WIDTH  = 8,
   parameter int OUT_WIDTH = 8,
   parameter int BUF_WIDTH = 32,
   parameter int AF_LEVEL  = BUF_WIDTH - IN_WIDTH,
   parameter int AE_LEVEL  = OUT_WIDTH,
   localparam int CI = $clog2(IN_WIDTH + 1),
   localparam int CO = $clog2(OUT_WIDTH + 1),
   localparam int CB = $clog2(BUF_WIDTH + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 flush,
   input  logic                 in_valid,
   input  logic [CI-1:0]        in_cnt,
   input  logic [0:IN_WIDTH-1]  in_data,
   output logic                 in_ready,
   input  logic                 out_ready,
   input  logic [CO-1:0]        out_cnt,
   output logic                 out_valid,
   output logic [0:OUT_WIDTH-1] out_data,
   output logic [CB-1:0]        used_cnt,
   output logic [CB-1:0]        empty_cnt,
   output logic                 almost_full,
   output logic                 almost_empty,
   output logic                 err_cnt
);

   localparam int AW = (BUF_WIDTH > 1) ? $clog2(BUF_WIDTH) : 1;

   logic [BUF_WIDTH-1:0] mem_q;
   logic [AW-1:0]        head_q, head_d;
   logic [AW-1:0]        tail_q, tail_d;
   logic [CB-1:0]        used_q, used_d;
   logic                 err_q, err_d;
   logic                 push, pop, bad_req;

   // Pointer plus offset, wrapped once; offsets never exceed BUF_WIDTH.
   function automatic logic [AW-1:0] wrap_add(input logic [AW-1:0] p,
                                              input int off);
      int s;
      s = int'(p) + off;
      if (s >= BUF_WIDTH) s = s - BUF_WIDTH;
      return AW'(s);
   endfunction

   assign in_ready  = !flush
                    && (int'(in_cnt) <= IN_WIDTH)
                    && (int'(in_cnt) <= BUF_WIDTH - int'(used_q));
   assign out_valid = !flush
                    && (int'(out_cnt) <= OUT_WIDTH)
                    && (int'(out_cnt) <= int'(used_q));

   assign push    = in_valid && in_ready;
   assign pop     = out_ready && out_valid;
   assign bad_req = (in_valid && (int'(in_cnt) > IN_WIDTH))
                 || (out_ready && (int'(out_cnt) > OUT_WIDTH));

   assign used_cnt     = used_q;
   assign empty_cnt    = CB'(BUF_WIDTH) - used_q;
   assign almost_full  = int'(used_q) >= AF_LEVEL;
   assign almost_empty = int'(used_q) <= AE_LEVEL;
   assign err_cnt      = err_q;

   // Next-state for pointers, occupancy and the sticky error flag.
   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      used_d = used_q;
      err_d  = err_q | bad_req;
      if (flush) begin
         head_d = '0;
         tail_d = '0;
         used_d = '0;
         err_d  = 1'b0;
      end else begin
         if (push) tail_d = wrap_add(tail_q, int'(in_cnt));
         if (pop)  head_d = wrap_add(head_q, int'(out_cnt));
         used_d = used_q
                + (push ? CB'(in_cnt) : '0)
                - (pop ? CB'(out_cnt) : '0);
      end
   end

   // Control state registers with asynchronous clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head_q <= '0;
         tail_q <= '0;
         used_q <= '0;
         err_q  <= 1'b0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         used_q <= used_d;
         err_q  <= err_d;
      end
   end

   // Storage is written only on accepted enqueues and is never cleared.
   always_ff @(posedge clk) begin
      for (int i = 0; i < IN_WIDTH; i++) begin
         if (push && (i < int'(in_cnt))) begin
            mem_q[wrap_add(tail_q, i)] <= in_data[i];
         end
      end
   end

   // Head window; bits beyond the stored count read as zero.
   always_comb begin
      out_data = '0;
      for (int i = 0; i < OUT_WIDTH; i++) begin
         if (i < int'(used_q)) out_data[i] = mem_q[wrap_add(head_q, i)];
      end
   end

endmodule

// File: tb/tb_stream_queue.sv
// tb_stream_queue: directed and randomized checks of stream_queue
// against a bit-queue reference model.
module tb_stream_queue;

   logic       clk = 1'b0;
   logic       reset;
   logic       flush;
   logic       in_valid;
   logic [3:0] in_cnt;
   logic [0:7] in_data;
   logic       in_ready;
   logic       out_ready;
   logic [3:0] out_cnt;
   logic       out_valid;
   logic [0:7] out_data;
   logic [4:0] used_cnt;
   logic [4:0] empty_cnt;
   logic       almost_full;
   logic       almost_empty;
   logic       err_cnt;

   bit mq[$];
   bit merr;
   int n_checks = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   stream_queue #(
      .IN_WIDTH(8), .OUT_WIDTH(8), .BUF_WIDTH(16),
      .AF_LEVEL(12), .AE_LEVEL(4)
   ) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_cnt(in_cnt), .in_data(in_data),
      .in_ready(in_ready), .out_ready(out_ready), .out_cnt(out_cnt),
      .out_valid(out_valid), .out_data(out_data),
      .used_cnt(used_cnt), .empty_cnt(empty_cnt),
      .almost_full(almost_full), .almost_empty(almost_empty),
      .err_cnt(err_cnt)
   );

   function automatic logic [0:7] m_out();
      logic [0:7] r;
      r = '0;
      for (int i = 0; i < 8; i++)
         if (i < mq.size()) r[i] = mq[i];
      return r;
   endfunction

   function automatic bit m_in_ready();
      return !flush && int'(in_cnt) <= 8
          && int'(in_cnt) <= 16 - mq.size();
   endfunction

   function automatic bit m_out_valid();
      return !flush && int'(out_cnt) <= 8
          && int'(out_cnt) <= mq.size();
   endfunction

   task automatic idle();
      flush = 0; in_valid = 0; in_cnt = 0; in_data = '0;
      out_ready = 0; out_cnt = 0;
   endtask

   // Update the model from the current inputs, then cross one edge.
   task automatic tick();
      bit ir, ov;
      ir = m_in_ready();
      ov = m_out_valid();
      if (flush) begin
         mq.delete();
         merr = 0;
      end else begin
         if ((in_valid && in_cnt > 4'd8) || (out_ready && out_cnt > 4'd8))
            merr = 1;
         if (out_ready && ov)
            for (int i = 0; i < int'(out_cnt); i++) void'(mq.pop_front());
         if (in_valid && ir)
            for (int i = 0; i < int'(in_cnt); i++) mq.push_back(in_data[i]);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic enq(input logic [3:0] c, input logic [0:7] d);
      idle(); in_valid = 1; in_cnt = c; in_data = d;
      tick(); idle();
   endtask

   task automatic deq(input logic [3:0] c);
      idle(); out_ready = 1; out_cnt = c;
      tick(); idle();
   endtask

   task automatic do_flush();
      idle(); flush = 1; tick(); idle();
   endtask

   task automatic test_reset();
      idle();
      reset = 0;
      #12 reset = 1;
      @(posedge clk); #1;
      enq(4'd8, 8'hA5);
      n_checks++;
      if (used_cnt !== 5'd8) begin
         n_fail++; $display("FAIL pre_reset_used got %0d want 8", used_cnt);
      end
      #2 reset = 0;
      mq.delete(); merr = 0;
      out_cnt = 4'd1;
      #1;
      n_checks++;
      if (used_cnt !== 5'd0) begin
         n_fail++; $display("FAIL reset_used got %0d want 0", used_cnt);
      end
      n_checks++;
      if (empty_cnt !== 5'd16) begin
         n_fail++; $display("FAIL reset_empty got %0d want 16", empty_cnt);
      end
      n_checks++;
      if (out_data !== 8'h00) begin
         n_fail++; $display("FAIL reset_data got %h want 00", out_data);
      end
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_ovalid got %b want 0", out_valid);
      end
      n_checks++;
      if (almost_empty !== 1'b1 || almost_full !== 1'b0 || err_cnt !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_flags got ae=%b af=%b err=%b want 1 0 0",
                  almost_empty, almost_full, err_cnt);
      end
      #1 reset = 1;
      idle();
      enq(4'd8, 8'h5A);
      n_checks++;
      if (used_cnt !== 5'd8 || out_data !== 8'h5A) begin
         n_fail++;
         $display("FAIL first_edge got used=%0d data=%h want 8 5a",
                  used_cnt, out_data);
      end
      do_flush();
   endtask

   task automatic test_partial();
      enq(4'd8, 8'hA5);
      enq(4'd4, 8'hC0);
      n_checks++;
      if (used_cnt !== 5'd12 || almost_full !== 1'b1) begin
         n_fail++;
         $display("FAIL partial_used got %0d af=%b want 12 1",
                  used_cnt, almost_full);
      end
      n_checks++;
      if (out_data !== 8'hA5) begin
         n_fail++; $display("FAIL partial_data got %h want a5", out_data);
      end
      deq(4'd8);
      n_checks++;
      if (used_cnt !== 5'd4 || out_data !== 8'hC0) begin
         n_fail++;
         $display("FAIL partial_deq got used=%0d data=%h want 4 c0",
                  used_cnt, out_data);
      end
      n_checks++;
      if (almost_empty !== 1'b1) begin
         n_fail++; $display("FAIL partial_ae got %b want 1", almost_empty);
      end
      do_flush();
   endtask

   task automatic test_wrap();
      enq(4'd8, 8'hF0);
      enq(4'd8, 8'h96);
      deq(4'd8);
      deq(4'd4);
      enq(4'd8, 8'h3C);
      n_checks++;
      if (used_cnt !== 5'd12) begin
         n_fail++; $display("FAIL wrap_used got %0d want 12", used_cnt);
      end
      n_checks++;
      if (out_data !== m_out() || out_data[4:7] !== 4'h3) begin
         n_fail++; $display("FAIL wrap_data got %h want %h", out_data, m_out());
      end
      deq(4'd4);
      n_checks++;
      if (out_data !== 8'h3C) begin
         n_fail++; $display("FAIL wrap_read got %h want 3c", out_data);
      end
      do_flush();
   endtask

   task automatic test_simul();
      enq(4'd8, 8'h81);
      enq(4'd8, 8'h7E);
      in_valid = 1; in_cnt = 4'd8; in_data = 8'hFF;
      out_ready = 1; out_cnt = 4'd8;
      #1;
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL simul_hs got ir=%b ov=%b want 0 1", in_ready, out_valid);
      end
      tick(); idle();
      n_checks++;
      if (used_cnt !== 5'd8 || out_data !== 8'h7E) begin
         n_fail++;
         $display("FAIL simul_next got used=%0d data=%h want 8 7e",
                  used_cnt, out_data);
      end
   endtask

   task automatic test_illegal();
      in_valid = 1; in_cnt = 4'd9; in_data = 8'hFF;
      #1;
      n_checks++;
      if (in_ready !== 1'b0) begin
         n_fail++; $display("FAIL illegal_ready got %b want 0", in_ready);
      end
      tick(); idle();
      n_checks++;
      if (err_cnt !== 1'b1 || used_cnt !== 5'd8) begin
         n_fail++;
         $display("FAIL illegal_err got err=%b used=%0d want 1 8",
                  err_cnt, used_cnt);
      end
      enq(4'd2, 8'h40);
      n_checks++;
      if (err_cnt !== 1'b1 || used_cnt !== 5'd10) begin
         n_fail++;
         $display("FAIL illegal_sticky got err=%b used=%0d want 1 10",
                  err_cnt, used_cnt);
      end
      flush = 1; in_valid = 1; in_cnt = 4'd1;
      #1;
      n_checks++;
      if (in_ready !== 1'b0) begin
         n_fail++; $display("FAIL flush_ready got %b want 0", in_ready);
      end
      tick(); idle();
      n_checks++;
      if (err_cnt !== 1'b0 || used_cnt !== 5'd0) begin
         n_fail++;
         $display("FAIL flush_clear got err=%b used=%0d want 0 0",
                  err_cnt, used_cnt);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         flush     = ($urandom_range(0, 31) == 0);
         in_valid  = 1'($urandom_range(0, 1));
         in_cnt    = 4'($urandom_range(0, 9));
         in_data   = 8'($urandom);
         out_ready = 1'($urandom_range(0, 1));
         out_cnt   = 4'($urandom_range(0, 9));
         #1;
         n_checks++;
         if (in_ready !== m_in_ready() || out_valid !== m_out_valid()) begin
            n_fail++;
            $display("FAIL rnd_hs cyc %0d got ir=%b ov=%b want %b %b",
                     n, in_ready, out_valid, m_in_ready(), m_out_valid());
         end
         tick();
         n_checks++;
         if (used_cnt !== 5'(mq.size()) || empty_cnt !== 5'(16 - mq.size())) begin
            n_fail++;
            $display("FAIL rnd_cnt cyc %0d got used=%0d free=%0d want %0d %0d",
                     n, used_cnt, empty_cnt, mq.size(), 16 - mq.size());
         end
         n_checks++;
         if (out_data !== m_out()) begin
            n_fail++;
            $display("FAIL rnd_data cyc %0d got %h want %h", n, out_data, m_out());
         end
         n_checks++;
         if (almost_full !== (mq.size() >= 12)
             || almost_empty !== (mq.size() <= 4)
             || err_cnt !== merr) begin
            n_fail++;
            $display("FAIL rnd_flags cyc %0d got af=%b ae=%b err=%b want %b %b %b",
                     n, almost_full, almost_empty, err_cnt,
                     mq.size() >= 12, mq.size() <= 4, merr);
         end
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_partial();
      test_wrap();
      test_simul();
      test_illegal();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
